// File: rtl/fir_tap_sequencer.sv
// Sequences one shared MAC across N_TAPS taps per sample: shift, MAC, drain, load, present.
// Sample accepted in IDLE; result presented N_TAPS+MAC_LAT+2 cycles later and held until out_ready.
module fir_tap_sequencer #(
    parameter int N_TAPS  = 8,
    parameter int TAP_W   = 3,
    parameter int MAC_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             shift_en,
    output logic [TAP_W-1:0] tap_sel,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             out_reg_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] sample_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC   = 3'd1,
        DRAIN = 3'd2,
        LOAD  = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam logic [TAP_W-1:0] LAST_TAP   = TAP_W'(N_TAPS - 1);
    localparam logic [2:0]       DRAIN_INIT = 3'((MAC_LAT > 0) ? (MAC_LAT - 1) : 0);

    generate
        if (N_TAPS < 2 || N_TAPS > (1 << TAP_W) || MAC_LAT < 0 || MAC_LAT > 7) begin : g_bad_params
            $error("fir_tap_sequencer: illegal parameter combination");
        end
    endgenerate

    state_t     state;
    logic [2:0] drain_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tap_sel    <= '0;
            drain_cnt  <= '0;
            sample_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state   <= MAC;
                        tap_sel <= '0;
                    end
                end
                MAC: begin
                    if (tap_sel == LAST_TAP) begin
                        tap_sel <= '0;
                        if (MAC_LAT > 0) begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_INIT;
                        end else begin
                            state <= LOAD;
                        end
                    end else begin
                        tap_sel <= tap_sel + 1'b1;
                    end
                end
                // Wait out the MAC pipeline so the output register sees the final sum.
                DRAIN: begin
                    if (drain_cnt == 3'd0) begin
                        state <= LOAD;
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                LOAD: state <= OUT;
                OUT: begin
                    if (out_ready) begin
                        sample_cnt <= sample_cnt + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // All controls decode from the state register; only shift_en sees in_valid directly.
    assign in_ready   = (state == IDLE) && !reset;
    assign shift_en   = in_valid && in_ready;
    assign acc_en     = (state == MAC);
    assign acc_clr    = (state == MAC) && (tap_sel == '0);
    assign out_reg_en = (state == LOAD);
    assign out_valid  = (state == OUT);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Randomised and directed bench for fir_tap_sequencer with a per-cycle timeline model.
module tb_fir_tap_sequencer;
    localparam int N  = 4;
    localparam int LA = 2;
    localparam int LB = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, iv_a, or_a, ir_a, se_a, ac_a, ae_a, ore_a, ov_a, bz_a;
    logic rst_b, iv_b, or_b, ir_b, se_b, ac_b, ae_b, ore_b, ov_b, bz_b;
    logic [2:0]  ts_a, ts_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    fir_tap_sequencer #(.N_TAPS(N), .TAP_W(3), .MAC_LAT(LA), .CNT_W(16)) dut_a (
        .clk(clk), .reset(rst_a), .in_valid(iv_a), .in_ready(ir_a), .shift_en(se_a),
        .tap_sel(ts_a), .acc_clr(ac_a), .acc_en(ae_a), .out_reg_en(ore_a),
        .out_valid(ov_a), .out_ready(or_a), .busy(bz_a), .sample_cnt(cnt_a));

    fir_tap_sequencer #(.N_TAPS(N), .TAP_W(3), .MAC_LAT(LB), .CNT_W(2)) dut_b (
        .clk(clk), .reset(rst_b), .in_valid(iv_b), .in_ready(ir_b), .shift_en(se_b),
        .tap_sel(ts_b), .acc_clr(ac_b), .acc_en(ae_b), .out_reg_en(ore_b),
        .out_valid(ov_b), .out_ready(or_b), .busy(bz_b), .sample_cnt(cnt_b));

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    // Model: pos = cycles since the accepting cycle, -1 when idle.
    int pos_a = -1, pos_b = -1;
    int mcnt_a = 0, mcnt_b = 0;
    int t_acc_a = 0, t_acc_b = 0, lat_a = -1, lat_b = -1, ovlat_a = -1;
    logic ov_prev_a = 1'b0;
    int acc_q_a[$];
    int acc_q_b[$];

    // {in_ready, shift_en, acc_en, acc_clr, out_reg_en, out_valid, busy, tap_sel}
    function automatic logic [9:0] expect_vec(int pos, int lat, logic rst, logic iv);
        logic ir, se, ae, ac, ore, ov, bz;
        logic [2:0] tp;
        {ir, se, ae, ac, ore, ov, bz} = '0;
        tp = 3'd0;
        if (!rst) begin
            if (pos < 0) begin
                ir = 1'b1;
                se = iv;
            end else begin
                bz = 1'b1;
                if (pos <= N) begin
                    ae = 1'b1;
                    ac = (pos == 1);
                    tp = 3'(pos - 1);
                end else if (pos == N + lat + 1) begin
                    ore = 1'b1;
                end else if (pos == N + lat + 2) begin
                    ov = 1'b1;
                end
            end
        end
        return {ir, se, ae, ac, ore, ov, bz, tp};
    endfunction

    function automatic int next_pos(int pos, int lat, logic iv, logic ordy);
        if (pos < 0) return iv ? 1 : -1;
        if (pos == N + lat + 2) return ordy ? -1 : pos;
        return pos + 1;
    endfunction

    always begin : compare
        logic [9:0] exp_v, got_v;
        @(negedge clk);
        #4;
        cycle++;
        if (rst_a) begin pos_a = -1; mcnt_a = 0; end
        if (rst_b) begin pos_b = -1; mcnt_b = 0; end

        exp_v = expect_vec(pos_a, LA, rst_a, iv_a);
        got_v = {ir_a, se_a, ae_a, ac_a, ore_a, ov_a, bz_a, ts_a};
        compared++;
        if (got_v !== exp_v || cnt_a !== 16'(mcnt_a)) begin
            mismatched++;
            $display("FAIL outputs_a cycle %0d: got %b cnt %0d, want %b cnt %0d",
                     cycle, got_v, cnt_a, exp_v, mcnt_a);
        end
        exp_v = expect_vec(pos_b, LB, rst_b, iv_b);
        got_v = {ir_b, se_b, ae_b, ac_b, ore_b, ov_b, bz_b, ts_b};
        compared++;
        if (got_v !== exp_v || cnt_b !== 2'(mcnt_b)) begin
            mismatched++;
            $display("FAIL outputs_b cycle %0d: got %b cnt %0d, want %b cnt %0d",
                     cycle, got_v, cnt_b, exp_v, mcnt_b);
        end

        if (se_a) begin t_acc_a = cycle; acc_q_a.push_back(cycle); end
        if (se_b) begin t_acc_b = cycle; acc_q_b.push_back(cycle); end
        if (ore_a) lat_a = cycle - t_acc_a;
        if (ore_b) lat_b = cycle - t_acc_b;
        if (ov_a && !ov_prev_a) ovlat_a = cycle - t_acc_a;
        ov_prev_a = ov_a;

        if (!rst_a) begin
            if (pos_a == N + LA + 2 && or_a) mcnt_a = (mcnt_a + 1) % 65536;
            pos_a = next_pos(pos_a, LA, iv_a, or_a);
        end
        if (!rst_b) begin
            if (pos_b == N + LB + 2 && or_b) mcnt_b = (mcnt_b + 1) % 4;
            pos_b = next_pos(pos_b, LB, iv_b, or_b);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(string name, int got, int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        iv_a = 1'b0; iv_b = 1'b0; or_a = 1'b0; or_b = 1'b0;
        repeat (3) step();
        #1;
        check("in_ready_during_reset", int'(ir_a), 0);

        step();
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        check("in_ready_after_release", int'(ir_a), 1);
        check("cnt_after_release", int'(cnt_a), 0);

        // Reset while tap 2 is being accumulated.
        step();
        iv_a = 1'b1;
        step();
        iv_a = 1'b0;
        for (int k = 0; k < 20 && !(ae_a && ts_a == 3'd2); k++) step();
        check("reached_tap2", int'(ae_a && ts_a == 3'd2), 1);
        rst_a = 1'b1;
        #1;
        check("mid_mac_reset_acc_en", int'(ae_a), 0);
        check("mid_mac_reset_tap_sel", int'(ts_a), 0);
        step();
        rst_a = 1'b0;
        repeat (15) step();
        check("cnt_after_abort", int'(cnt_a), 0);

        // Single sample with out_ready high.
        or_a = 1'b1;
        iv_a = 1'b1;
        step();
        iv_a = 1'b0;
        repeat (12) step();
        check("load_latency_a", lat_a, 7);
        check("valid_latency_a", ovlat_a, 8);
        check("cnt_single", int'(cnt_a), 1);

        // Back-to-back samples.
        acc_q_a.delete();
        iv_a = 1'b1;
        for (int k = 0; k < 60 && acc_q_a.size() < 3; k++) step();
        iv_a = 1'b0;
        check("b2b_accepts_a", acc_q_a.size(), 3);
        if (acc_q_a.size() == 3) begin
            check("b2b_period_a_1", acc_q_a[1] - acc_q_a[0], 9);
            check("b2b_period_a_2", acc_q_a[2] - acc_q_a[1], 9);
        end
        repeat (12) step();
        check("cnt_b2b", int'(cnt_a), 4);

        // Output stall.
        or_a = 1'b0;
        iv_a = 1'b1;
        step();
        iv_a = 1'b0;
        for (int k = 0; k < 20 && !ov_a; k++) step();
        check("stall_valid_rises", int'(ov_a), 1);
        iv_a = 1'b1;
        repeat (20) step();
        #1;
        check("stall_valid_held", int'(ov_a), 1);
        check("stall_no_shift", int'(se_a), 0);
        iv_a = 1'b0;
        or_a = 1'b1;
        step();
        #1;
        check("stall_release_idle", int'(ir_a), 1);
        check("cnt_after_stall", int'(cnt_a), 5);

        // MAC_LAT=0 instance: five samples, 2-bit counter wraps.
        or_b = 1'b1;
        iv_b = 1'b1;
        acc_q_b.delete();
        for (int k = 0; k < 80 && acc_q_b.size() < 5; k++) step();
        iv_b = 1'b0;
        check("b2b_accepts_b", acc_q_b.size(), 5);
        if (acc_q_b.size() == 5) check("b2b_period_b", acc_q_b[4] - acc_q_b[3], 7);
        repeat (10) step();
        check("load_latency_b", lat_b, 5);
        check("cnt_wrap_b", int'(cnt_b), 1);

        // Random traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            rst_a = ($urandom_range(0, 199) == 0);
            rst_b = ($urandom_range(0, 199) == 0);
            iv_a  = ($urandom_range(0, 3) != 0);
            iv_b  = ($urandom_range(0, 3) != 0);
            or_a  = ($urandom_range(0, 2) != 0);
            or_b  = ($urandom_range(0, 2) != 0);
            step();
        end
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
- Time-multiplexed FIR controller that sequences one shared multiply-accumulate datapath across N_TAPS taps for each input sample.
- Drives the shift enable of the enabled-register delay line, the tap/coefficient select, and accumulator clear/enable, then loads the output register.
- Sits between the upstream sample source and the downstream consumer, with valid/ready handshakes on both sides.

Parameters:
- N_TAPS, 8, number of filter taps; must be at least 2.
- TAP_W, 3, width of tap_sel; N_TAPS must not exceed 2**TAP_W.
- MAC_LAT, 1, pipeline latency in cycles from acc_en to the accumulator result being valid; 0 to 7.
- CNT_W, 16, width of the completed-sample counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  controller can accept a sample.
- shift_en  out  1  enable for the delay-line registers; the sample is captured on the accepting edge.
- tap_sel  out  TAP_W  tap index, also the coefficient address, for the current MAC cycle.
- acc_clr  out  1  the accumulator loads the product instead of adding it; asserted with acc_en on tap 0 only.
- acc_en  out  1  the accumulator updates this cycle.
- out_reg_en  out  1  enable for the output result register; one-cycle pulse.
- out_valid  out  1  filtered result available.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  high in every state except IDLE.
- sample_cnt  out  CNT_W  number of completed output handshakes.

Behaviour:
- States: IDLE, MAC, DRAIN, LOAD, OUT. All outputs decode from the registered state and counters unless stated otherwise.
- Reset (asynchronous, any state, mid-operation included):
  - state=IDLE, tap_sel=0, drain counter=0, sample_cnt=0.
  - acc_en, acc_clr, out_reg_en, out_valid, shift_en = 0.
  - in_ready=0 while reset is asserted.
  - An in-flight sample is abandoned; no partial result is ever presented.
- IDLE:
  - in_ready=1.
  - shift_en = in_valid & in_ready, combinational, same cycle as the handshake.
  - On handshake: go to MAC with tap_sel=0.
- MAC, exactly N_TAPS cycles:
  - acc_en=1 every cycle; tap_sel counts 0..N_TAPS-1; acc_clr=1 only when tap_sel=0.
  - After tap_sel=N_TAPS-1: go to DRAIN if MAC_LAT>0, otherwise go straight to LOAD.
  - in_ready=0; in_valid is ignored.
- DRAIN: exactly MAC_LAT cycles; all enables 0; a counter counts down, then go to LOAD.
- LOAD: one cycle; out_reg_en=1; next state OUT.
- OUT:
  - out_valid=1 and held until out_valid & out_ready.
  - On that handshake: sample_cnt increments (wraps modulo 2**CNT_W) and the state returns to IDLE.
  - out_ready low stalls indefinitely; no other output changes during the stall.
- Latency: handshake in cycle T, out_reg_en in cycle T+N_TAPS+MAC_LAT+1, out_valid from T+N_TAPS+MAC_LAT+2.
- Maximum throughput: one sample per N_TAPS+MAC_LAT+3 cycles (out_ready held high, in_valid held high).
- tap_sel returns to 0 when leaving MAC and holds 0 outside MAC.
- Each cycle exactly one state is active; acc_en and out_reg_en are never asserted together.
- out_ready high outside OUT has no effect.

Test Plan:
- Reset release, N_TAPS=4, MAC_LAT=2:
  - in_ready=0 during reset, 1 on the first cycle after release; all other outputs 0; sample_cnt=0.
- Single sample: in_valid at cycle 0, out_ready=1 ->
  - shift_en=1 in cycle 0.
  - acc_en in cycles 1-4 with tap_sel 0,1,2,3; acc_clr only in cycle 1.
  - No enables in cycles 5-6; out_reg_en in cycle 7; out_valid in cycle 8.
  - IDLE and in_ready=1 in cycle 9; sample_cnt=1.
- Back-to-back: in_valid held high for 3 samples -> handshakes every 9 cycles; sample_cnt=3; in_ready never high outside IDLE.
- Output stall: out_ready=0 for 20 cycles after out_valid rises -> out_valid stays 1, in_ready=0, shift_en=0; completes one cycle after out_ready=1.
- Reset mid-MAC: assert reset at tap_sel=2 -> immediate IDLE, acc_en=0, tap_sel=0; no out_valid; sample_cnt unchanged at its pre-reset 0.
- MAC_LAT=0 with CNT_W=2: five samples -> LOAD directly follows the last MAC cycle, 7-cycle period; sample_cnt wraps 3 -> 0 -> 1.
